// File: rtl/ofifo_drain.sv
// Drains OFIFO psum rows into the psum SRAM at base_addr + k.
// Build option OFIFO_DRAIN_ACC_EN: read-modify-write, adding each row to SRAM.
module ofifo_drain #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_bw = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [addr_bw-1:0]     base_addr,
    input  logic [addr_bw-1:0]     num_rows,
    input  logic                   ofifo_valid,
    input  logic [psum_bw*col-1:0] ofifo_data,
    output logic                   ofifo_rd,
    output logic                   mem_cen,
    output logic                   mem_wen,
    output logic [addr_bw-1:0]     mem_addr,
    output logic [psum_bw*col-1:0] mem_d,
    input  logic [psum_bw*col-1:0] mem_q,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int DW = psum_bw * col;

`ifdef OFIFO_DRAIN_ACC_EN
    typedef enum logic [1:0] {IDLE, FETCH, ACCUM, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, DRAIN, FIN} state_t;
`endif

    state_t             state, nxt_state;
    logic [addr_bw-1:0] base_q, nxt_base;
    logic [addr_bw-1:0] nrows_q, nxt_nrows;
    logic [addr_bw-1:0] issued_q, nxt_issued;
    logic               nxt_cen, nxt_wen;
    logic [addr_bw-1:0] nxt_addr;
    logic [DW-1:0]      nxt_d;
    logic               nxt_busy, nxt_done, nxt_err;

    logic [addr_bw-1:0] row_addr;
    logic [addr_bw-1:0] issued_inc;
    logic               last_pop;
    logic               empty;
    logic               pop_ok;

    assign row_addr   = base_q + issued_q;
    assign issued_inc = issued_q + addr_bw'(1);
    assign last_pop   = (issued_inc == nrows_q);
    assign empty      = (issued_q == nrows_q);
    assign pop_ok     = ofifo_valid && (issued_q < nrows_q);

`ifdef OFIFO_DRAIN_ACC_EN
    logic [DW-1:0] row_q, nxt_row;
    logic [DW-1:0] acc_sum;

    assign ofifo_rd = (state == FETCH) && pop_ok;

    // Lanes wrap independently; no carry crosses a lane boundary.
    always_comb begin
        acc_sum = '0;
        for (int i = 0; i < col; i++) begin
            acc_sum[i*psum_bw +: psum_bw] =
                mem_q[i*psum_bw +: psum_bw] + row_q[i*psum_bw +: psum_bw];
        end
    end
`else
    logic unused_q;
    assign unused_q = ^mem_q;
    assign ofifo_rd = (state == DRAIN) && pop_ok;
`endif

    always_comb begin
        nxt_state  = state;
        nxt_base   = base_q;
        nxt_nrows  = nrows_q;
        nxt_issued = issued_q;
        nxt_cen    = 1'b1;
        nxt_wen    = 1'b1;
        nxt_addr   = mem_addr;
        nxt_d      = mem_d;
        nxt_busy   = busy;
        nxt_done   = 1'b0;
        nxt_err    = err | (start & busy);
`ifdef OFIFO_DRAIN_ACC_EN
        nxt_row    = row_q;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    nxt_base   = base_addr;
                    nxt_nrows  = num_rows;
                    nxt_issued = '0;
                    nxt_busy   = 1'b1;
`ifdef OFIFO_DRAIN_ACC_EN
                    nxt_state  = FETCH;
`else
                    nxt_state  = DRAIN;
`endif
                end
            end
`ifdef OFIFO_DRAIN_ACC_EN
            FETCH: begin
                if (ofifo_rd) begin
                    nxt_cen    = 1'b0;
                    nxt_addr   = row_addr;
                    nxt_row    = ofifo_data;
                    nxt_issued = issued_inc;
                    nxt_state  = ACCUM;
                end else if (empty) begin
                    nxt_done  = 1'b1;
                    nxt_busy  = 1'b0;
                    nxt_state = IDLE;
                end
            end
            ACCUM: begin
                nxt_cen   = 1'b0;
                nxt_wen   = 1'b0;
                nxt_d     = acc_sum;
                nxt_state = empty ? FIN : FETCH;
            end
`else
            DRAIN: begin
                if (ofifo_rd) begin
                    nxt_cen    = 1'b0;
                    nxt_wen    = 1'b0;
                    nxt_addr   = row_addr;
                    nxt_d      = ofifo_data;
                    nxt_issued = issued_inc;
                    if (last_pop) nxt_state = FIN;
                end else if (empty) begin
                    nxt_done  = 1'b1;
                    nxt_busy  = 1'b0;
                    nxt_state = IDLE;
                end
            end
`endif
            FIN: begin
                nxt_done  = 1'b1;
                nxt_busy  = 1'b0;
                nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            base_q   <= '0;
            nrows_q  <= '0;
            issued_q <= '0;
            mem_cen  <= 1'b1;
            mem_wen  <= 1'b1;
            mem_addr <= '0;
            mem_d    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef OFIFO_DRAIN_ACC_EN
            row_q    <= '0;
`endif
        end else begin
            state    <= nxt_state;
            base_q   <= nxt_base;
            nrows_q  <= nxt_nrows;
            issued_q <= nxt_issued;
            mem_cen  <= nxt_cen;
            mem_wen  <= nxt_wen;
            mem_addr <= nxt_addr;
            mem_d    <= nxt_d;
            busy     <= nxt_busy;
            done     <= nxt_done;
            err      <= nxt_err;
`ifdef OFIFO_DRAIN_ACC_EN
            row_q    <= nxt_row;
`endif
        end
    end

    // last_pop is only consulted by the plain-write FSM
`ifdef OFIFO_DRAIN_ACC_EN
    logic unused_last;
    assign unused_last = last_pop;
`endif

endmodule

// File: tb/tb_ofifo_drain.sv
// Scoreboard bench for ofifo_drain: OFIFO and SRAM models, write monitor.
// Honours OFIFO_DRAIN_ACC_EN to match the accumulate build.
module tb_ofifo_drain;

    localparam int COL   = 8;
    localparam int PBW   = 16;
    localparam int ABW   = 11;
    localparam int DW    = COL * PBW;
    localparam int DEPTH = 1 << ABW;

    typedef struct {
        logic [ABW-1:0] addr;
        logic [DW-1:0]  data;
    } wr_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [ABW-1:0] base_addr = '0;
    logic [ABW-1:0] num_rows = '0;
    logic           ofifo_valid = 1'b0;
    logic [DW-1:0]  ofifo_data = '0;
    logic           ofifo_rd;
    logic           mem_cen;
    logic           mem_wen;
    logic [ABW-1:0] mem_addr;
    logic [DW-1:0]  mem_d;
    logic [DW-1:0]  mem_q;
    logic           busy;
    logic           done;
    logic           err;

    logic [DW-1:0] sram    [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] fifo_q  [$];
    wr_t           exp_q   [$];

    int checks   = 0;
    int errors   = 0;
    int pops     = 0;
    int wr_count = 0;
    int vmode    = 0;

    ofifo_drain #(.col(COL), .psum_bw(PBW), .addr_bw(ABW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .base_addr(base_addr), .num_rows(num_rows),
        .ofifo_valid(ofifo_valid), .ofifo_data(ofifo_data),
        .ofifo_rd(ofifo_rd), .mem_cen(mem_cen), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Flow-through read: data for the address on the bus this cycle
    assign mem_q = sram[mem_addr];

    task automatic chk(input string name, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        logic [DW-1:0] r;
        for (int i = 0; i < COL; i++) begin
            r[i*PBW +: PBW] = a[i*PBW +: PBW] + b[i*PBW +: PBW];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] make_row(input int kind, input int k);
        logic [DW-1:0] r;
        for (int i = 0; i < COL; i++) begin
            case (kind)
                0:       r[i*PBW +: PBW] = PBW'((k + 1) * 16 + i);
                2:       r[i*PBW +: PBW] = (k == 0) ? 16'h0001 : 16'hFFFF;
                default: r[i*PBW +: PBW] = PBW'($urandom());
            endcase
        end
        return r;
    endfunction

    // OFIFO + SRAM write model
    initial begin : drv
        logic           rd_s;
        logic           wr_s;
        logic [ABW-1:0] wa;
        logic [DW-1:0]  wd;
        logic           gate;
        int             cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            rd_s = ofifo_rd;
            wr_s = reset && !mem_cen && !mem_wen;
            wa   = mem_addr;
            wd   = mem_d;
            @(posedge clk);
            if (rd_s && fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
                pops++;
            end
            #1;
            if (wr_s) sram[wa] = wd;
            cyc++;
            case (vmode)
                0:       gate = 1'b1;
                1:       gate = (cyc % 3 == 0);
                default: gate = ($urandom_range(0, 3) != 0);
            endcase
            ofifo_valid = gate && (fifo_q.size() > 0);
            ofifo_data  = ofifo_valid ? fifo_q[0]
                                      : {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    end

    // Write monitor
    initial begin : mon
        wr_t e;
        forever begin
            @(negedge clk);
            if (reset && !mem_cen && !mem_wen) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %h data %h expected none",
                             mem_addr, mem_d);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", DW'(mem_addr), DW'(e.addr));
                    chk("wr_data", mem_d, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    function automatic wr_t expect_row(input logic [ABW-1:0] a,
                                       input logic [DW-1:0] row);
        wr_t e;
        e.addr = a;
`ifdef OFIFO_DRAIN_ACC_EN
        e.data = lane_add(ref_mem[a], row);
`else
        e.data = row;
`endif
        ref_mem[a] = e.data;
        return e;
    endfunction

    task automatic run_drain(input logic [ABW-1:0] base, input int n,
                             input int mode, input int kind, input bit mid_start);
        logic [DW-1:0] row;
        int  p0, w0, edges, exp_edges;
        bit  busy_ok;
        vmode = mode;
        for (int k = 0; k < n; k++) begin
            row = make_row(kind, k);
            fifo_q.push_back(row);
            exp_q.push_back(expect_row(base + ABW'(k), row));
        end
`ifdef OFIFO_DRAIN_ACC_EN
        exp_edges = (n == 0) ? 1 : 2 * n + 1;
`else
        exp_edges = (n == 0) ? 1 : n + 1;
`endif
        p0 = pops;
        w0 = wr_count;
        busy_ok = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; num_rows = ABW'(n);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", DW'(busy), DW'(1));
        edges = 0;
        while (!done && edges < 40 * n + 40) begin
            if (!busy) busy_ok = 1'b0;
            if (mid_start && edges == 1) begin
                start = 1'b1;
                base_addr = base + ABW'(100);
                num_rows = ABW'(7);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        chk("done_seen", DW'(done), DW'(1));
        chk("busy_at_done", DW'(busy), DW'(0));
        chk("cen_at_done", DW'(mem_cen), DW'(1));
        chk("busy_held", DW'(busy_ok), DW'(1));
        if (mode == 0) chk("latency", DW'(edges), DW'(exp_edges));
        chk("pops", DW'(pops - p0), DW'(n));
        chk("writes", DW'(wr_count - w0), DW'(n));
        chk("exp_empty", DW'(exp_q.size()), DW'(0));
        @(posedge clk); #1;
        chk("done_pulse", DW'(done), DW'(0));
    endtask

    initial begin : main
        logic [DW-1:0] row;
        logic [DW-1:0] v;
        int p0, w0, cnt;
        for (int a = 0; a < DEPTH; a++) begin
            sram[a] = '0;
            ref_mem[a] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd", DW'(ofifo_rd), DW'(0));
        chk("rst_cen", DW'(mem_cen), DW'(1));
        chk("rst_wen", DW'(mem_wen), DW'(1));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_err", DW'(err), DW'(0));
        reset = 1'b1;

        run_drain(11'h010, 4, 0, 0, 1'b0);
        run_drain(11'h040, 3, 1, 1, 1'b0);
        run_drain(11'h7FE, 3, 0, 1, 1'b0);

        fifo_q.push_back(make_row(1, 0));
        run_drain(11'h100, 0, 0, 1, 1'b0);
        fifo_q.delete();

        chk("err_clear", DW'(err), DW'(0));
        run_drain(11'h080, 4, 0, 1, 1'b1);
        chk("err_set", DW'(err), DW'(1));

        // Reset after two of five pops; only row 0's write completes
        vmode = 0;
        for (int k = 0; k < 5; k++) begin
            row = make_row(1, k);
            fifo_q.push_back(row);
            if (k == 0) exp_q.push_back(expect_row(11'h200, row));
        end
        p0 = pops;
        w0 = wr_count;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 11'h200; num_rows = 11'd5;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        while (pops - p0 < 2 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("two_pops", DW'(pops - p0), DW'(2));
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_rd", DW'(ofifo_rd), DW'(0));
        chk("mid_rst_cen", DW'(mem_cen), DW'(1));
        chk("mid_rst_wen", DW'(mem_wen), DW'(1));
        chk("mid_rst_addr", DW'(mem_addr), DW'(0));
        chk("mid_rst_d", mem_d, '0);
        chk("mid_rst_busy", DW'(busy), DW'(0));
        chk("mid_rst_done", DW'(done), DW'(0));
        chk("mid_rst_err", DW'(err), DW'(0));
        chk("mid_rst_writes", DW'(wr_count - w0), DW'(1));
        fifo_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        run_drain(11'h055, 1, 0, 1, 1'b0);

`ifdef OFIFO_DRAIN_ACC_EN
        for (int i = 0; i < COL; i++) begin
            v[i*PBW +: PBW] = 16'h7FFF;
        end
        sram[11'h300] = v;
        ref_mem[11'h300] = v;
        for (int i = 0; i < COL; i++) begin
            v[i*PBW +: PBW] = 16'hFFFF;
        end
        sram[11'h301] = v;
        ref_mem[11'h301] = v;
        run_drain(11'h300, 2, 0, 2, 1'b0);
        v = sram[11'h300];
        chk("acc_wrap_pos", DW'(v[PBW-1:0]), DW'(16'h8000));
        v = sram[11'h301];
        chk("acc_neg", DW'(v[DW-1 -: PBW]), DW'(16'hFFFE));
`else
        v = '0;
`endif

        for (int t = 0; t < 4; t++) begin
            run_drain(ABW'($urandom_range(0, DEPTH - 1)),
                      $urandom_range(1, 10), 2, 1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
